// File: rtl/bcd_pkg.sv
// Shared FSM state type, seven-segment constants and nibble helpers for bcd_seg_driver.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'b1011_1111;

  // Active-low patterns, bit 7 = dp (kept off), bit 0 = segment a
  localparam logic [7:0] SEG_0 = 8'b1100_0000;
  localparam logic [7:0] SEG_1 = 8'b1111_1001;
  localparam logic [7:0] SEG_2 = 8'b1010_0100;
  localparam logic [7:0] SEG_3 = 8'b1011_0000;
  localparam logic [7:0] SEG_4 = 8'b1001_1001;
  localparam logic [7:0] SEG_5 = 8'b1001_0010;
  localparam logic [7:0] SEG_6 = 8'b1000_0010;
  localparam logic [7:0] SEG_7 = 8'b1111_1000;
  localparam logic [7:0] SEG_8 = 8'b1000_0000;
  localparam logic [7:0] SEG_9 = 8'b1001_0000;

  function automatic logic [7:0] digit_to_seg(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Double-dabble correction: a nibble of 5 or more would exceed 9 after doubling
  function automatic logic [3:0] dd_adjust(input logic [3:0] n);
    logic [3:0] r;
    if (n >= 4'd5) begin
      r = n + 4'd3;
    end else begin
      r = n;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_decode.sv
// One seven-segment digit: BCD nibble to active-low pattern, with dash and blank overrides.
module seg_decode
  import bcd_pkg::*;
(
  input  logic [3:0] i_nib,
  input  logic       i_blank,
  input  logic       i_dash,
  output logic [7:0] o_seg
);

  // Dash wins over blanking so an overflowed value never looks like a short number
  always_comb begin
    o_seg = SEG_BLANK;
    if (i_dash) begin
      o_seg = SEG_DASH;
    end else if (i_blank) begin
      o_seg = SEG_BLANK;
    end else begin
      o_seg = digit_to_seg(i_nib);
    end
  end

endmodule

// File: rtl/bcd_seg_driver.sv
// Sequential binary-to-BCD (double dabble, one bit per clock) and multi-digit seven-segment driver.
// Optional build macro BCD_LEADING_ZERO_BLANK_EN blanks leading zero digits on seg.
module bcd_seg_driver
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [8*DIGITS-1:0]   seg,
  output logic                  overflow
);

  localparam int              CW       = $clog2(WIDTH + 1);
  localparam int              BW       = 4 * DIGITS;
  localparam logic [31:0]     MAX_VAL  = 32'(10 ** DIGITS - 1);
  localparam logic [CW-1:0]   CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  state_t              r_state;
  state_t              w_next_state;
  logic [WIDTH-1:0]    r_bin;
  logic [BW-1:0]       r_acc;
  logic [BW-1:0]       w_acc_adj;
  logic [BW-1:0]       w_acc_shift;
  logic [BW-1:0]       r_bcd;
  logic [CW-1:0]       r_cnt;
  logic                r_ovf_pend;
  logic                r_ovf;
  logic                r_out_valid;
  logic [8*DIGITS-1:0] w_seg;
  logic [8*DIGITS-1:0] r_seg;
  logic [DIGITS-1:0]   w_blank;
  logic                w_accept;
  logic                w_last;

  assign w_accept = in_valid && (r_state == IDLE);
  assign w_last   = (r_state == SHIFT) && (r_cnt == CNT_ONE);

  // Per-nibble add-3 correction ahead of the shift
  always_comb begin
    w_acc_adj = r_acc;
    for (int k = 0; k < DIGITS; k++) begin
      w_acc_adj[4*k +: 4] = dd_adjust(r_acc[4*k +: 4]);
    end
  end

  // The accumulator's top bit falls off here; only relevant when the value overflows
  assign w_acc_shift = (w_acc_adj << 1) | BW'(r_bin[WIDTH-1]);

`ifdef BCD_LEADING_ZERO_BLANK_EN
  // Blank digit k when it and every digit above it are zero; digit 0 always shows
  always_comb begin
    logic v_zero;
    v_zero  = 1'b1;
    w_blank = {DIGITS{1'b0}};
    for (int k = DIGITS - 1; k > 0; k--) begin
      v_zero     = v_zero && (w_acc_shift[4*k +: 4] == 4'd0);
      w_blank[k] = v_zero;
    end
  end
`else
  assign w_blank = {DIGITS{1'b0}};
`endif

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    seg_decode u_seg_decode (
      .i_nib   (w_acc_shift[4*k +: 4]),
      .i_blank (w_blank[k]),
      .i_dash  (r_ovf_pend),
      .o_seg   (w_seg[8*k +: 8])
    );
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next_state = SHIFT;
        end else begin
          w_next_state = IDLE;
        end
      end
      SHIFT: begin
        if (w_last) begin
          w_next_state = DONE;
        end else begin
          w_next_state = SHIFT;
        end
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Conversion datapath; results are captured on the final shift, i.e. the edge entering DONE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bin       <= {WIDTH{1'b0}};
      r_acc       <= {BW{1'b0}};
      r_cnt       <= {CW{1'b0}};
      r_ovf_pend  <= 1'b0;
      r_bcd       <= {BW{1'b0}};
      r_seg       <= {(8*DIGITS){1'b1}};
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (w_accept) begin
        r_bin      <= in_data;
        r_acc      <= {BW{1'b0}};
        r_cnt      <= CNT_LOAD;
        r_ovf_pend <= (32'(in_data) > MAX_VAL);
      end else if (r_state == SHIFT) begin
        r_acc <= w_acc_shift;
        r_bin <= r_bin << 1;
        r_cnt <= r_cnt - CNT_ONE;
        if (w_last) begin
          r_bcd       <= w_acc_shift;
          r_seg       <= w_seg;
          r_ovf       <= r_ovf_pend;
          r_out_valid <= 1'b1;
        end else begin
          r_out_valid <= 1'b0;
        end
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign bcd       = r_bcd;
  assign seg       = r_seg;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_bcd_seg_driver.sv
// Self-checking bench for bcd_seg_driver: decimal-arithmetic model plus directed literal checks.
module tb_bcd_seg_driver;

  localparam int W = 8;
`ifdef BCD_LEADING_ZERO_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  logic         clk      = 1'b0;
  logic         rst      = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data  = '0;

  logic        rdy_a, ov_a, ovf_a;
  logic [11:0] bcd_a;
  logic [23:0] seg_a;
  logic        rdy_b, ov_b, ovf_b;
  logic [7:0]  bcd_b;
  logic [15:0] seg_b;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int          busy    = 0;
  int unsigned cur_val = 0;
  logic [11:0] e_bcd_a = '0;
  logic [23:0] e_seg_a = '1;
  logic        e_ovf_a = 1'b0;
  logic [7:0]  e_bcd_b = '0;
  logic [15:0] e_seg_b = '1;
  logic        e_ovf_b = 1'b0;

  bcd_seg_driver #(.WIDTH(W), .DIGITS(3)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a), .in_data(in_data),
    .out_valid(ov_a), .bcd(bcd_a), .seg(seg_a), .overflow(ovf_a)
  );

  bcd_seg_driver #(.WIDTH(W), .DIGITS(2)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_b), .in_data(in_data),
    .out_valid(ov_b), .bcd(bcd_b), .seg(seg_b), .overflow(ovf_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pat(input int unsigned d);
    logic [7:0] t [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    return t[d];
  endfunction

  function automatic logic [31:0] exp_bcd(input int unsigned v, input int nd);
    logic [31:0] r = '0;
    int unsigned q = v;
    for (int k = 0; k < nd; k++) begin
      r[4*k +: 4] = 4'(q % 10);
      q = q / 10;
    end
    return r;
  endfunction

  function automatic logic [31:0] exp_seg(input int unsigned v, input int nd);
    logic [31:0] r = '1;
    int unsigned lim = 1;
    int unsigned p = 1;
    for (int k = 0; k < nd; k++) lim = lim * 10;
    for (int k = 0; k < nd; k++) begin
      if (v >= lim) r[8*k +: 8] = 8'hBF;
      else if (BLANK_EN && k > 0 && v < p) r[8*k +: 8] = 8'hFF;
      else r[8*k +: 8] = pat((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  // Model: busy counts edges until idle again; results appear as busy drops to 1
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy    <= 0;
      e_bcd_a <= '0;
      e_seg_a <= '1;
      e_ovf_a <= 1'b0;
      e_bcd_b <= '0;
      e_seg_b <= '1;
      e_ovf_b <= 1'b0;
    end else if (busy == 0) begin
      if (in_valid) begin
        busy    <= W + 1;
        cur_val <= 32'(in_data);
      end
    end else begin
      busy <= busy - 1;
      if (busy == 2) begin
        e_bcd_a <= 12'(exp_bcd(cur_val, 3));
        e_seg_a <= 24'(exp_seg(cur_val, 3));
        e_ovf_a <= (cur_val > 999);
        e_bcd_b <= 8'(exp_bcd(cur_val, 2));
        e_seg_b <= 16'(exp_seg(cur_val, 2));
        e_ovf_b <= (cur_val > 99);
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    chk("in_ready_a", 32'(rdy_a), 32'(busy == 0));
    chk("out_valid_a", 32'(ov_a), 32'(busy == 1));
    chk("bcd_a", 32'(bcd_a), 32'(e_bcd_a));
    chk("seg_a", 32'(seg_a), 32'(e_seg_a));
    chk("ovf_a", 32'(ovf_a), 32'(e_ovf_a));
    chk("in_ready_b", 32'(rdy_b), 32'(busy == 0));
    chk("out_valid_b", 32'(ov_b), 32'(busy == 1));
    chk("bcd_b", 32'(bcd_b), 32'(e_bcd_b));
    chk("seg_b", 32'(seg_b), 32'(e_seg_b));
    chk("ovf_b", 32'(ovf_b), 32'(e_ovf_b));
  end

  task automatic send(input logic [W-1:0] v);
    int n = 0;
    @(negedge clk);
    while (!rdy_a && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", 32'(rdy_a), 32'd1);
    in_valid = 1'b1;
    in_data  = v;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_ov();
    int n = 0;
    while (!ov_a && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("out_valid_timeout", 32'(ov_a), 32'd1);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int t1;
    int n;
    logic [7:0] d2_exp;
    d2_exp = BLANK_EN ? 8'hFF : 8'hC0;

    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_seg", 32'(seg_a), 32'h00FF_FFFF);
    chk("rst_bcd", 32'(bcd_a), 32'h0);
    chk("rst_ready", 32'(rdy_a), 32'd1);
    chk("rst_ov", 32'(ov_a), 32'd0);
    chk("rst_ovf", 32'(ovf_a), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    send(8'd26);
    wait_ov();
    chk("lit_26", 32'(bcd_a), 32'h026);
    send(8'd39);
    wait_ov();
    chk("lit_39_bcd", 32'(bcd_a), 32'h039);
    chk("lit_39_d1", 32'(seg_a[15:8]), 32'hB0);
    chk("lit_39_d0", 32'(seg_a[7:0]), 32'h90);
    chk("lit_39_d2", 32'(seg_a[23:16]), 32'(d2_exp));

    // back-to-back with in_valid held high
    @(negedge clk);
    n = 0;
    while (!rdy_a && n < 40) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b1;
    in_data  = 8'd255;
    @(negedge clk);
    t0 = cyc;
    in_data = 8'd0;
    wait_ov();
    chk("lit_255", 32'(bcd_a), 32'h255);
    @(negedge clk);
    n = 0;
    while (!rdy_a && n < 40) begin
      @(negedge clk);
      n++;
    end
    t1 = cyc + 1;
    chk("period", 32'(t1 - t0), 32'd10);
    @(negedge clk);
    in_valid = 1'b0;
    wait_ov();
    chk("lit_0_bcd", 32'(bcd_a), 32'h0);
    chk("lit_0_d0", 32'(seg_a[7:0]), 32'hC0);

    // two-digit instance: overflow then recovery
    send(8'd123);
    wait_ov();
    chk("lit_123_ovf2", 32'(ovf_b), 32'd1);
    chk("lit_123_seg2", 32'(seg_b), 32'hBFBF);
    chk("lit_123_bcd2", 32'(bcd_b), 32'h23);
    chk("lit_123_bcd3", 32'(bcd_a), 32'h123);
    send(8'd99);
    wait_ov();
    chk("lit_99_ovf2", 32'(ovf_b), 32'd0);
    chk("lit_99_bcd2", 32'(bcd_b), 32'h99);

    // in_valid while busy is ignored
    send(8'd200);
    repeat (2) @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'd77;
    @(negedge clk);
    in_valid = 1'b0;
    wait_ov();
    chk("lit_busy_ignored", 32'(bcd_a), 32'h200);

    // async reset in the middle of a conversion
    send(8'd150);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_bcd", 32'(bcd_a), 32'h0);
    chk("mid_rst_seg", 32'(seg_a), 32'h00FF_FFFF);
    chk("mid_rst_ready", 32'(rdy_a), 32'd1);
    chk("mid_rst_ov", 32'(ov_a), 32'd0);
    chk("mid_rst_ovf2", 32'(ovf_b), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (15) @(negedge clk);
    send(8'd5);
    wait_ov();
    chk("lit_5", 32'(bcd_a), 32'h005);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
